// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block-sequencer state encoding, block geometry,
// and the IV / round-constant tables consumed by the compression datapath.
package sha256_pkg;

  localparam int WORDS_PER_BLK = 16;
  localparam int ROUNDS        = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_EXPAND = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [31:0] H0 = 32'h6a09e667;
  localparam logic [31:0] H1 = 32'hbb67ae85;
  localparam logic [31:0] H2 = 32'h3c6ef372;
  localparam logic [31:0] H3 = 32'ha54ff53a;
  localparam logic [31:0] H4 = 32'h510e527f;
  localparam logic [31:0] H5 = 32'h9b05688c;
  localparam logic [31:0] H6 = 32'h1f83d9ab;
  localparam logic [31:0] H7 = 32'h5be0cd19;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_at(input logic [5:0] t);
    return K[t];
  endfunction

endpackage

// File: rtl/sha256_blk_ctrl.sv
// SHA-256 block sequencer: loads 16 message words per block into the scheduler,
// turns each returned W word into a compression-round strobe, then updates H.
module sha256_blk_ctrl #(
  parameter int WORDS_PER_BLK = 16,
  parameter int ROUNDS        = 64,
  parameter int BLK_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [31:0]          word_i,
  input  logic                 word_valid_i,
  input  logic                 word_last_i,
  output logic                 word_ready_o,
  output logic [31:0]          sch_m_o,
  output logic                 sch_m_dv_o,
  input  logic [31:0]          sch_w_i,
  input  logic                 sch_w_dv_i,
  output logic                 rnd_en_o,
  output logic [5:0]           rnd_idx_o,
  output logic [31:0]          rnd_w_o,
  output logic                 hinit_o,
  output logic                 hupd_o,
  output logic                 digest_valid_o,
  output logic                 busy_o,
  output logic [BLK_CNT_W-1:0] blk_cnt_o
);
  import sha256_pkg::*;

  localparam logic [4:0] LD_MAX  = 5'(WORDS_PER_BLK);
  localparam logic [6:0] RND_MAX = 7'(ROUNDS);

  state_e               r_state, w_state_nxt;
  logic [4:0]           r_ld_cnt;
  logic [6:0]           r_rnd_cnt;
  logic                 r_last;
  logic [BLK_CNT_W-1:0] r_blk_cnt;
  logic [31:0]          r_m;
  logic                 r_m_dv;

  logic w_in_load, w_rnd_win, w_word_ready, w_word_hs, w_rnd_en;
  logic w_ld_done, w_rnd_done;

  assign w_in_load    = (r_state == ST_LOAD);
  assign w_rnd_win    = (r_state == ST_LOAD) || (r_state == ST_EXPAND);
  assign w_word_ready = w_in_load && (r_ld_cnt < LD_MAX);
  assign w_word_hs    = w_word_ready && word_valid_i;
  // Round counter stops at ROUNDS so a misbehaving scheduler cannot wrap it.
  assign w_rnd_en     = w_rnd_win && sch_w_dv_i && (r_rnd_cnt < RND_MAX);

  // "Done" includes the event firing this cycle so the FSM leaves one cycle later.
  assign w_ld_done  = (r_ld_cnt == LD_MAX) || (w_word_hs && (r_ld_cnt == LD_MAX - 5'd1));
  assign w_rnd_done = (r_rnd_cnt == RND_MAX) || (w_rnd_en && (r_rnd_cnt == RND_MAX - 7'd1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start_i) w_state_nxt = ST_INIT;
      ST_INIT:   w_state_nxt = ST_LOAD;
      ST_LOAD:   if (w_ld_done) w_state_nxt = w_rnd_done ? ST_UPDATE : ST_EXPAND;
      ST_EXPAND: if (w_rnd_done) w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = r_last ? ST_DONE : ST_LOAD;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ld_cnt  <= '0;
      r_rnd_cnt <= '0;
      r_last    <= 1'b0;
      r_blk_cnt <= '0;
      r_m       <= '0;
      r_m_dv    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_m_dv  <= w_word_hs;
      if (w_word_hs) r_m <= word_i;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_blk_cnt <= '0;
            r_last    <= 1'b0;
            r_ld_cnt  <= '0;
            r_rnd_cnt <= '0;
          end
        end
        ST_LOAD, ST_EXPAND: begin
          if (w_word_hs) begin
            r_ld_cnt <= r_ld_cnt + 5'd1;
            if (r_ld_cnt == LD_MAX - 5'd1) r_last <= word_last_i;
          end
          if (w_rnd_en) r_rnd_cnt <= r_rnd_cnt + 7'd1;
        end
        ST_UPDATE: begin
          if (r_blk_cnt != '1) r_blk_cnt <= r_blk_cnt + 1'b1;
          r_ld_cnt  <= '0;
          r_rnd_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign word_ready_o   = w_word_ready;
  assign sch_m_o        = r_m;
  assign sch_m_dv_o     = r_m_dv;
  assign rnd_en_o       = w_rnd_en;
  assign rnd_idx_o      = w_rnd_en ? r_rnd_cnt[5:0] : 6'd0;
  assign rnd_w_o        = w_rnd_en ? sch_w_i : 32'd0;
  assign hinit_o        = (r_state == ST_INIT);
  assign hupd_o         = (r_state == ST_UPDATE);
  assign digest_valid_o = (r_state == ST_DONE);
  assign busy_o         = (r_state != ST_IDLE);
  assign blk_cnt_o      = r_blk_cnt;

endmodule

// File: tb/tb_sha256_blk_ctrl.sv
// Scoreboard bench for sha256_blk_ctrl: drivers push expected M and round
// values into queues, a negedge monitor pops and compares them.
module tb_sha256_blk_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] word_i = '0;
  logic        word_valid_i = 1'b0;
  logic        word_last_i = 1'b0;
  logic        word_ready_o;
  logic [31:0] sch_m_o;
  logic        sch_m_dv_o;
  logic [31:0] sch_w_i = '0;
  logic        sch_w_dv_i = 1'b0;
  logic        rnd_en_o;
  logic [5:0]  rnd_idx_o;
  logic [31:0] rnd_w_o;
  logic        hinit_o, hupd_o, digest_valid_o, busy_o;
  logic [15:0] blk_cnt_o;

  sha256_blk_ctrl #(.WORDS_PER_BLK(16), .ROUNDS(64), .BLK_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .word_i(word_i), .word_valid_i(word_valid_i), .word_last_i(word_last_i),
    .word_ready_o(word_ready_o), .sch_m_o(sch_m_o), .sch_m_dv_o(sch_m_dv_o),
    .sch_w_i(sch_w_i), .sch_w_dv_i(sch_w_dv_i),
    .rnd_en_o(rnd_en_o), .rnd_idx_o(rnd_idx_o), .rnd_w_o(rnd_w_o),
    .hinit_o(hinit_o), .hupd_o(hupd_o), .digest_valid_o(digest_valid_o),
    .busy_o(busy_o), .blk_cnt_o(blk_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] w;
  } rnd_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_q[$];
  rnd_t        r_q[$];
  rnd_t        mon_e;
  logic [31:0] mon_m;
  int n_hinit = 0, n_hupd = 0, n_digest = 0, n_rnd = 0;
  int rnds_blk = 0, m_blk = 0, cyc = 0, hupd_cyc = -10;
  logic [31:0] blk_words [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every DUT output event against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rnds_blk = 0;
      m_blk = 0;
    end else begin
      if (sch_m_dv_o) begin
        m_blk++;
        if (m_q.size() == 0) fail("sch_m_unexpected");
        else begin
          mon_m = m_q.pop_front();
          chk("sch_m", sch_m_o, mon_m);
        end
      end
      if (rnd_en_o) begin
        n_rnd++;
        rnds_blk++;
        if (r_q.size() == 0) fail("rnd_unexpected");
        else begin
          mon_e = r_q.pop_front();
          chk("rnd_idx", rnd_idx_o, mon_e.idx);
          chk("rnd_w", rnd_w_o, mon_e.w);
        end
      end
      if (hinit_o) n_hinit++;
      if (hupd_o) begin
        n_hupd++;
        chk("rounds_before_hupd", rnds_blk, 64);
        chk("loads_before_hupd", m_blk, 16);
        rnds_blk = 0;
        m_blk = 0;
        hupd_cyc = cyc;
      end
      if (digest_valid_o) begin
        n_digest++;
        chk("digest_after_hupd", cyc, hupd_cyc + 1);
      end
    end
  end

  task automatic drive_words(input bit last, input bit toggle);
    int i = 0;
    int guard = 0;
    bit ph = 1'b1;
    while (i < 16 && guard < 3000) begin
      guard++;
      @(posedge clk); #1;
      word_valid_i = toggle ? ph : 1'b1;
      ph = !ph;
      word_i = blk_words[i];
      word_last_i = (i == 15) ? last : 1'b0;
      @(negedge clk);
      if (word_valid_i && word_ready_o) begin
        m_q.push_back(blk_words[i]);
        i++;
      end
    end
    if (i < 16) fail("load_timeout");
    // A 17th word must be refused.
    @(posedge clk); #1;
    word_valid_i = 1'b1;
    word_i = 32'hdeadbeef;
    word_last_i = 1'b0;
    @(negedge clk);
    chk("ready_after_16", word_ready_o, 0);
    @(posedge clk); #1;
    word_valid_i = 1'b0;
  endtask

  // Scheduler model: echoes each M one cycle later, then emits 48 more W words.
  task automatic run_sched(input int gap, input int abort_at);
    int n_m = 0, n_w = 0, gapc = 0, guard = 0;
    bit have = 1'b0;
    logic [31:0] pend = '0;
    rnd_t e;
    while (n_w < 64) begin
      guard++;
      if (guard > 3000) begin
        fail("sched_timeout");
        break;
      end
      @(posedge clk); #1;
      sch_w_dv_i = 1'b0;
      if (abort_at >= 0 && n_w == abort_at) begin
        rst = 1'b1;
        return;
      end
      if (have) begin
        sch_w_i = pend;
        sch_w_dv_i = 1'b1;
        e.idx = n_w[5:0];
        e.w = pend;
        r_q.push_back(e);
        n_w++;
        have = 1'b0;
      end else if (n_m == 16 && n_w >= 16) begin
        if (gapc == 0) begin
          sch_w_i = 32'h5a000000 | (n_w * 32'h00010101);
          sch_w_dv_i = 1'b1;
          e.idx = n_w[5:0];
          e.w = sch_w_i;
          r_q.push_back(e);
          n_w++;
          gapc = gap;
        end else gapc--;
      end
      @(negedge clk);
      if (sch_m_dv_o) begin
        pend = sch_m_o;
        have = 1'b1;
        n_m++;
      end
    end
    @(posedge clk); #1;
    sch_w_dv_i = 1'b0;
  endtask

  task automatic set_block(input bit abc, input int seed);
    for (int i = 0; i < 16; i++)
      blk_words[i] = abc ? 32'h0 : (32'h10000000 + seed * 32'h100 + i);
    if (abc) begin
      blk_words[0] = 32'h61626380;
      blk_words[15] = 32'h00000018;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_msg(input int nblk, input bit toggle, input int gap, input bit busy_start, input string tag);
    int h0 = n_hinit, u0 = n_hupd, d0 = n_digest, r0 = n_rnd;
    int guard = 0;
    pulse_start();
    for (int b = 0; b < nblk; b++) begin
      set_block(b == nblk - 1, b);
      fork
        drive_words(b == nblk - 1, toggle);
        run_sched(gap, -1);
        begin
          if (busy_start) begin
            repeat (5) @(posedge clk);
            #1 start_i = 1'b1;
            @(posedge clk); #1 start_i = 1'b0;
          end
        end
      join
    end
    while (n_digest == d0 && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    if (n_digest == d0) fail({tag, "_digest_timeout"});
    chk({tag, "_hinit_cnt"}, n_hinit - h0, 1);
    chk({tag, "_hupd_cnt"}, n_hupd - u0, nblk);
    chk({tag, "_rnd_cnt"}, n_rnd - r0, 64 * nblk);
    chk({tag, "_digest_cnt"}, n_digest - d0, 1);
    chk({tag, "_blk_cnt"}, blk_cnt_o, nblk);
    chk({tag, "_rq_empty"}, r_q.size(), 0);
    chk({tag, "_mq_empty"}, m_q.size(), 0);
    @(negedge clk); #1;
    chk({tag, "_idle_busy"}, busy_o, 0);
    chk({tag, "_idle_digest"}, digest_valid_o, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_word_ready"}, word_ready_o, 0);
    chk({tag, "_sch_m_dv"}, sch_m_dv_o, 0);
    chk({tag, "_sch_m"}, sch_m_o, 0);
    chk({tag, "_rnd_en"}, rnd_en_o, 0);
    chk({tag, "_rnd_idx"}, rnd_idx_o, 0);
    chk({tag, "_rnd_w"}, rnd_w_o, 0);
    chk({tag, "_hinit"}, hinit_o, 0);
    chk({tag, "_hupd"}, hupd_o, 0);
    chk({tag, "_digest"}, digest_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_blk_cnt"}, blk_cnt_o, 0);
  endtask

  initial begin
    int h0, u0, d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // W strobe in IDLE must be ignored.
    h0 = n_hinit;
    @(posedge clk); #1;
    sch_w_dv_i = 1'b1;
    sch_w_i = 32'hcafef00d;
    @(negedge clk);
    chk("idle_w_rnd_en", rnd_en_o, 0);
    chk("idle_w_rnd_w", rnd_w_o, 0);
    @(posedge clk); #1;
    sch_w_dv_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("idle_hinit", n_hinit - h0, 0);

    run_msg(1, 1'b0, 0, 1'b0, "single");
    run_msg(2, 1'b0, 0, 1'b0, "two_blk");
    run_msg(1, 1'b1, 0, 1'b0, "toggle");
    run_msg(1, 1'b0, 3, 1'b0, "gap3");
    run_msg(1, 1'b0, 0, 1'b1, "busy_start");

    // Abort at round 30: outputs clear next cycle, no hash update.
    u0 = n_hupd;
    d0 = n_digest;
    pulse_start();
    set_block(1'b1, 0);
    fork
      drive_words(1'b1, 1'b0);
      run_sched(0, 30);
    join
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("abort");
    #1;
    chk("abort_hupd", n_hupd - u0, 0);
    chk("abort_digest", n_digest - d0, 0);
    rst = 1'b0;
    r_q.delete();
    m_q.delete();
    run_msg(1, 1'b0, 0, 1'b0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
